// File: rtl/sys_bus_ctrl_if.sv
// Snooping system-bus signal bundle between the bus controller and the two nodes.
// The controller side uses the master modport; the node side uses slave.
interface sys_bus_ctrl_if;
   logic [1:0]  REQ;
   logic [1:0]  GNT;
   logic        RW;
   logic        BUS_INV;
   logic [23:0] ADDR_I;
   logic [31:0] DATA_I;
   logic [1:0]  PHIT_I;
   logic [1:0]  PHITM_I;
   logic [31:0] WB_DATA_I;
   logic        WB_V_I;
   logic        SINT;
   logic        PINV_O;
   logic [23:0] ADDR_O;
   logic [31:0] DATA_O;
   logic        DR;
   logic        SHARED;

   modport master (
      input  REQ, RW, BUS_INV, ADDR_I, DATA_I,
      input  PHIT_I, PHITM_I, WB_DATA_I, WB_V_I,
      output GNT, SINT, PINV_O, ADDR_O, DATA_O, DR, SHARED
   );

   modport slave (
      output REQ, RW, BUS_INV, ADDR_I, DATA_I,
      output PHIT_I, PHITM_I, WB_DATA_I, WB_V_I,
      input  GNT, SINT, PINV_O, ADDR_O, DATA_O, DR, SHARED
   );
endinterface

// File: rtl/sys_bus_ctrl.sv
// Two-node round-robin bus controller with snoop broadcast, modified-line
// intervention and a local 32-bit memory array.
module sys_bus_ctrl #(
   parameter int MEM_LAT = 2,
   parameter int AW_MEM  = 8
) (
   input  logic           SCLK,
   input  logic           SRST,
   sys_bus_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_SNOOP, S_SWAIT,
      S_WBWAIT, S_MEM, S_RESP, S_HOLD
   } state_t;

   // The SWAIT cycle overlaps the first memory cycle.
   localparam logic [3:0] LP_CNT = 4'(MEM_LAT - 1);

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_gnt;
   logic                r_last;
   logic                r_node;
   logic                r_rw;
   logic                r_inv;
   logic [23:0]         r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_data;
   logic [3:0]          r_cnt;
   logic                r_shared;
   logic [31:0]         r_mem [0:(1<<AW_MEM)-1];

   logic                w_win;
   logic [1:0]          w_others;
   logic                w_hit;
   logic                w_hitm;
   logic                w_mem_wr;
   logic                w_mem_rd;
   logic                w_wb;
   logic                w_sint;
   logic                w_dr;
   logic [AW_MEM-1:0]   w_idx;

   assign w_win    = (&bus.REQ) ? ~r_last : bus.REQ[1];
   assign w_others = r_node ? 2'b01 : 2'b10;
   assign w_hit    = |(bus.PHIT_I & w_others);
   assign w_hitm   = |(bus.PHITM_I & w_others);
   assign w_idx    = r_addr[AW_MEM-1:0];

   always_ff @(posedge SCLK or posedge SRST) begin
      if (SRST) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_mem_wr = 1'b0;
      w_mem_rd = 1'b0;
      w_wb     = 1'b0;
      unique case (r_state)
         S_IDLE:   if (|bus.REQ) w_next = S_GRANT;
         S_GRANT:  w_next = S_SNOOP;
         S_SNOOP:  w_next = S_SWAIT;
         S_SWAIT:  w_next = (!r_rw && w_hitm) ? S_WBWAIT : S_MEM;
         S_WBWAIT: begin
            if (bus.WB_V_I) begin
               w_wb   = 1'b1;
               w_next = S_RESP;
            end
         end
         S_MEM: begin
            if (r_cnt <= 4'd1) begin
               w_mem_wr = r_rw;
               w_mem_rd = ~r_rw;
               w_next   = S_RESP;
            end
         end
         S_RESP:   w_next = S_HOLD;
         S_HOLD:   if (!bus.REQ[r_node]) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge SCLK or posedge SRST) begin
      if (SRST) begin
         r_gnt    <= 2'b00;
         r_last   <= 1'b1;
         r_node   <= 1'b0;
         r_rw     <= 1'b0;
         r_inv    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_data   <= '0;
         r_cnt    <= '0;
         r_shared <= 1'b0;
      end else begin
         if (r_state == S_IDLE && |bus.REQ) begin
            r_node <= w_win;
            r_last <= w_win;
            r_gnt  <= w_win ? 2'b10 : 2'b01;
         end
         if (r_state == S_HOLD && !bus.REQ[r_node])
            r_gnt <= 2'b00;
         if (r_state == S_GRANT) begin
            r_addr  <= bus.ADDR_I;
            r_rw    <= bus.RW;
            r_inv   <= bus.BUS_INV;
            r_wdata <= bus.DATA_I;
         end
         if (r_state == S_SWAIT) begin
            r_cnt    <= LP_CNT;
            r_shared <= !r_rw && !r_inv && (w_hit || w_hitm);
         end
         if (r_state == S_MEM)
            r_cnt <= (r_cnt > 4'd1) ? r_cnt - 4'd1 : 4'd0;
         if (w_mem_rd) r_data <= r_mem[w_idx];
         if (w_wb)     r_data <= bus.WB_DATA_I;
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge SCLK) begin
      if (!SRST && w_mem_wr)  r_mem[w_idx] <= r_wdata;
      else if (!SRST && w_wb) r_mem[w_idx] <= bus.WB_DATA_I;
   end

   assign w_sint     = (r_state == S_SNOOP);
   assign w_dr       = (r_state == S_RESP);
   assign bus.GNT    = r_gnt;
   assign bus.SINT   = w_sint;
   assign bus.PINV_O = w_sint & (r_rw | r_inv);
   assign bus.ADDR_O = r_addr;
   assign bus.DATA_O = r_data;
   assign bus.DR     = w_dr;
   assign bus.SHARED = w_dr & r_shared;
endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Bench for sys_bus_ctrl: transaction-level timeline model, per-cycle compare,
// directed scenarios followed by randomized two-node traffic.
module tb_sys_bus_ctrl;
   localparam int MEM_LAT = 2;

   logic SCLK = 1'b0;
   logic SRST;
   sys_bus_ctrl_if bus();

   sys_bus_ctrl #(.MEM_LAT(MEM_LAT), .AW_MEM(8)) dut (
      .SCLK (SCLK),
      .SRST (SRST),
      .bus  (bus)
   );

   always #5 SCLK = ~SCLK;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   logic check_en = 1'b0;

   logic [1:0]  e_gnt;
   logic        e_sint, e_pinv, e_dr, e_shared;
   logic [23:0] e_addr;
   logic [31:0] e_data;

   logic [31:0] m_mem [int];
   logic [7:0]  widx [$];
   int          last_g;
   logic [1:0]  pend;
   int          last_t0;

   logic [31:0] o_data;
   logic        o_shared, o_pinv;
   logic [1:0]  o_gnt;
   int          o_dr_cyc;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", n, cyc, a, e);
      end
   endtask

   always @(negedge SCLK) begin
      if (check_en) begin
         chk("GNT", 32'(bus.GNT), 32'(e_gnt));
         chk("SINT", 32'(bus.SINT), 32'(e_sint));
         chk("PINV_O", 32'(bus.PINV_O), 32'(e_pinv));
         chk("DR", 32'(bus.DR), 32'(e_dr));
         chk("SHARED", 32'(bus.SHARED), 32'(e_shared));
         chk("DATA_O", bus.DATA_O, e_data);
         if (e_sint) chk("ADDR_O", 32'(bus.ADDR_O), 32'(e_addr));
         if (bus.DR === 1'b1) begin
            o_data   = bus.DATA_O;
            o_shared = bus.SHARED;
            o_dr_cyc = cyc;
         end
         if (bus.SINT === 1'b1) o_pinv = bus.PINV_O;
         if (bus.GNT !== 2'b00) o_gnt = bus.GNT;
      end
   end

   task automatic tick();
      @(posedge SCLK);
      #1;
      cyc++;
   endtask

   task automatic junk();
      bus.PHIT_I    = 2'($urandom);
      bus.PHITM_I   = 2'($urandom);
      bus.WB_V_I    = 1'($urandom);
      bus.WB_DATA_I = $urandom;
   endtask

   task automatic rst_chk();
      chk("RST_GNT", 32'(bus.GNT), 32'd0);
      chk("RST_SINT", 32'(bus.SINT), 32'd0);
      chk("RST_PINV", 32'(bus.PINV_O), 32'd0);
      chk("RST_DR", 32'(bus.DR), 32'd0);
      chk("RST_SHARED", 32'(bus.SHARED), 32'd0);
      chk("RST_ADDR_O", 32'(bus.ADDR_O), 32'd0);
      chk("RST_DATA_O", bus.DATA_O, 32'd0);
   endtask

   task automatic note_write(input logic [7:0] idx, input logic [31:0] d);
      if (!m_mem.exists(int'(idx))) widx.push_back(idx);
      m_mem[int'(idx)] = d;
   endtask

   task automatic model_reset();
      last_g  = 1;
      pend    = 2'b00;
      e_gnt   = 2'b00;
      e_sint  = 1'b0;
      e_pinv  = 1'b0;
      e_dr    = 1'b0;
      e_shared = 1'b0;
      e_addr  = '0;
      e_data  = '0;
   endtask

   // One bus tenure: arbitration, snoop, data phase, release.
   task automatic txn(input logic [1:0] newreq, input logic rw,
                      input logic inv, input logic [23:0] a,
                      input logic [31:0] wd, input logic [1:0] ph,
                      input logic [1:0] phm, input logic [31:0] wbd,
                      input int wbdly, input int hk, input bit abort);
      logic [1:0] req, gbit, oth;
      logic [7:0] idx;
      logic       wbpath, hit;
      int w;
      idx = a[7:0];
      req = pend | newreq;
      w = (req == 2'b11) ? 1 - last_g : (req[1] ? 1 : 0);
      gbit = (w == 1) ? 2'b10 : 2'b01;
      pend = req & ~gbit;
      last_g = w;
      oth = ~gbit;
      wbpath = !rw && |(phm & oth);
      hit = |((ph | phm) & oth);
      bus.REQ = req;
      bus.RW = rw;
      bus.BUS_INV = inv;
      bus.ADDR_I = a;
      bus.DATA_I = wd;
      junk();
      last_t0 = cyc;
      tick();
      e_gnt = gbit;
      junk();
      tick();
      bus.ADDR_I = 24'($urandom);
      bus.DATA_I = $urandom;
      bus.RW = 1'($urandom);
      bus.BUS_INV = 1'($urandom);
      junk();
      e_sint = 1'b1;
      e_pinv = rw | inv;
      e_addr = a;
      tick();
      e_sint = 1'b0;
      e_pinv = 1'b0;
      junk();
      bus.PHIT_I = ph;
      bus.PHITM_I = phm;
      tick();
      if (abort) begin
         check_en = 1'b0;
         #1;
         SRST = 1'b1;
         #1;
         rst_chk();
         @(posedge SCLK);
         #2;
         SRST = 1'b0;
         cyc++;
         bus.REQ = 2'b00;
         model_reset();
         check_en = 1'b1;
         return;
      end
      if (wbpath) begin
         for (int i = 0; i < wbdly; i++) begin
            junk();
            bus.WB_V_I = 1'b0;
            tick();
         end
         junk();
         bus.WB_V_I = 1'b1;
         bus.WB_DATA_I = wbd;
         tick();
         note_write(idx, wbd);
         e_data = wbd;
      end else begin
         for (int i = 4; i < 3 + MEM_LAT; i++) begin
            junk();
            tick();
         end
         if (rw) note_write(idx, wd);
         else    e_data = m_mem[int'(idx)];
      end
      junk();
      e_dr = 1'b1;
      e_shared = !rw && !inv && hit;
      tick();
      e_dr = 1'b0;
      e_shared = 1'b0;
      for (int i = 0; i < hk; i++) begin
         junk();
         tick();
      end
      junk();
      bus.REQ = pend;
      tick();
      e_gnt = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0]  nr;
      logic        rw;
      logic [7:0]  ri;
      SRST = 1'b1;
      bus.REQ = 2'b00;
      bus.RW = 1'b0;
      bus.BUS_INV = 1'b0;
      bus.ADDR_I = '0;
      bus.DATA_I = '0;
      bus.PHIT_I = '0;
      bus.PHITM_I = '0;
      bus.WB_DATA_I = '0;
      bus.WB_V_I = 1'b0;
      model_reset();
      repeat (2) @(posedge SCLK);
      #1;
      rst_chk();
      SRST = 1'b0;
      check_en = 1'b1;

      // round robin after reset
      txn(2'b11, 1'b1, 1'b0, 24'h000030, 32'h0000_0030, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("RR_FIRST", 32'(o_gnt), 32'h1);
      txn(2'b00, 1'b1, 1'b0, 24'h000031, 32'h0000_0031, 2'b00, 2'b00, 0, 0, 1, 0);
      chk("RR_SECOND", 32'(o_gnt), 32'h2);
      txn(2'b11, 1'b1, 1'b0, 24'h000032, 32'h0000_0032, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("RR_THIRD", 32'(o_gnt), 32'h1);
      txn(2'b00, 1'b1, 1'b0, 24'h000033, 32'h0000_0033, 2'b00, 2'b00, 0, 0, 2, 0);

      // write then plain read
      txn(2'b01, 1'b1, 1'b0, 24'h000010, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 0, 0);
      txn(2'b01, 1'b0, 1'b0, 24'h000010, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("RD_DATA", o_data, 32'hDEADBEEF);
      chk("RD_SHARED", 32'(o_shared), 32'h0);
      chk("RD_LAT", 32'(o_dr_cyc - last_t0), 32'd5);

      // modified-line intervention
      txn(2'b10, 1'b0, 1'b0, 24'h000044, 32'h0, 2'b00, 2'b01, 32'h12345678, 2, 0, 0);
      chk("WB_DATA", o_data, 32'h12345678);
      chk("WB_LAT", 32'(o_dr_cyc - last_t0), 32'd7);
      txn(2'b01, 1'b0, 1'b0, 24'h000044, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("WB_MEM", o_data, 32'h12345678);

      // shared and read-for-ownership
      txn(2'b01, 1'b0, 1'b0, 24'h000010, 32'h0, 2'b10, 2'b00, 0, 0, 0, 0);
      chk("SH_SET", 32'(o_shared), 32'h1);
      txn(2'b01, 1'b0, 1'b1, 24'h000010, 32'h0, 2'b10, 2'b00, 0, 0, 0, 0);
      chk("INV_PINV", 32'(o_pinv), 32'h1);
      chk("INV_SHARED", 32'(o_shared), 32'h0);

      // own snoop bits ignored
      txn(2'b01, 1'b1, 1'b0, 24'h000020, 32'hA5A5_0020, 2'b01, 2'b01, 0, 0, 0, 0);
      chk("OWN_W_LAT", 32'(o_dr_cyc - last_t0), 32'd5);
      txn(2'b01, 1'b0, 1'b0, 24'h000010, 32'h0, 2'b01, 2'b01, 0, 0, 0, 0);
      chk("OWN_R_LAT", 32'(o_dr_cyc - last_t0), 32'd5);
      chk("OWN_R_SH", 32'(o_shared), 32'h0);

      // reset during the memory phase of a write
      txn(2'b01, 1'b1, 1'b0, 24'h000010, 32'hCAFEF00D, 2'b00, 2'b00, 0, 0, 0, 1);
      txn(2'b01, 1'b0, 1'b0, 24'h000010, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("ABORT_OLD", o_data, 32'hDEADBEEF);

      for (int n = 0; n < 60; n++) begin
         nr = 2'($urandom_range(1, 3));
         rw = 1'($urandom);
         ri = rw ? 8'($urandom) : widx[$urandom_range(0, widx.size() - 1)];
         txn(nr, rw, 1'($urandom), {16'($urandom), ri}, $urandom,
             2'($urandom), 2'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), 0);
      end
      if (pend != 2'b00)
         txn(2'b00, 1'b1, 1'b0, 24'h0000FF, 32'h1, 2'b00, 2'b00, 0, 0, 0, 0);

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
